load_store_unit: RTL and testbench
==================================

# load_store_unit

Processor-side initiator for the word-organised data memory in the single-cycle RV32I datapath. Accepts one load or store per request from the core, performs byte/halfword lane selection, sign/zero extension and detection of misaligned or illegal accesses. Sub-word stores use read-modify-write, because the data memory has only a whole-word write enable. Sits between the execute stage and the data memory, and stalls the core through a valid/ready handshake.

## Interface

- `WID`, 32, data and address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  unit can accept a request (high only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- `req_addr`  in  WID  byte address
- `req_wdata`  in  WID  store data (low byte/half used for sb/sh)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  WID  extended load data (0 for stores/errors)
- `resp_err`  out  1  misaligned or illegal access; valid with resp_valid
- `mem_addr`  out  WID  word-aligned address {addr[WID-1:2],2'b00}
- `mem_wd`  out  WID  write data to memory
- `mem_we`  out  1  memory write enable
- `mem_rd`  in  WID  combinational read data from memory

## Operation

- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr and wdata, then classify:
  - Error if any of the following holds; go to RESP with err=1, no memory access:
    - halfword access with addr[0]=1
    - word access with addr[1:0]≠0
    - load funct3 ∈ {011,110,111}
    - store funct3 ∉ {000,001,010}
  - Load → LOAD.
  - sw → WRITE.
  - sb/sh → RMW_RD.
- LOAD: sample mem_rd and extract the lane selected by addr[1:0]:
  - lb/lh sign-extend.
  - lbu/lhu zero-extend.
  - lw passes through.
  - Register the result into resp_rdata, then go to RESP.
- RMW_RD: sample mem_rd and register a merged word:
  - sb: the byte at lane addr[1:0] is replaced by wdata[7:0].
  - sh: the half at lane addr[1] is replaced by wdata[15:0].
  - Then go to WRITE.
- WRITE: mem_we=1; mem_wd = wdata (sw) or the merged word; then go to RESP.
- RESP: resp_valid=1 with resp_rdata and resp_err held; then go to IDLE.
- mem_we is asserted only in WRITE, for exactly one cycle per store. It is never asserted for an error.
- mem_addr is driven from the latched address in all non-IDLE states. In IDLE it is driven from req_addr.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_wd=0.
- Latency from the accept edge to resp_valid high:
  - load: 2 cycles
  - sw: 2 cycles
  - sb/sh: 3 cycles
  - error: 1 cycle
- Throughput: one request in flight. The next request can be accepted in the cycle after RESP (IDLE).
- The memory write commits on the clk edge that ends WRITE. The RMW read uses the memory contents before that edge.
- req_valid with req_ready=0 is ignored. The core must hold the request and its fields until accepted. Fields are latched only at the accept edge.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronously).
  - A pending RMW is abandoned with no write.
  - No resp_valid is issued for the aborted request.

## Structure

- Package `lsu_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum/localparams.
- Sub-module `lsu_align`: purely combinational. Takes the word, addr[1:0], funct3 and wdata. Produces the extended load value, the merged store word and the misalignment/illegal flag. The FSM lives in `load_store_unit`.

## Test plan

1. Memory word @0x10 = 0x80817F01. Expected loads:
   - lb 0x12 → 0xFFFFFF81
   - lbu 0x12 → 0x00000081
   - lh 0x12 → 0xFFFF8081
   - lhu 0x10 → 0x00007F01
   - lw 0x10 → 0x80817F01
   - Each: resp_valid 2 cycles after accept, resp_err=0.
2. Word @0x10 = 0x11223344; sb wdata=0xFFFFFFAB to 0x13 → word 0xAB223344. mem_we high for exactly 1 cycle; resp_valid 3 cycles after accept.
3. Word @0x14 = 0xDEADBEEF; sh wdata=0x00001234 to 0x16 → word 0x1234BEEF. Word @0x18 unchanged.
4. lw 0x0A, sh 0x21 and load funct3=011 → each gives resp_err=1, resp_rdata=0, one cycle after accept. mem_we never asserted; memory unchanged.
5. Word @0x20 = 0x00000000; sb 0x55 to 0x20; rst_n pulsed low during WRITE → mem_we drops immediately, word stays 0x00000000, no resp_valid. req_ready=1 after release.
6. Back-to-back with req_valid held high: sw 0xCAFEF00D @0x30, then lw @0x30 → second request accepted only when req_ready=1; lw returns 0xCAFEF00D.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes and FSM states.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
endpackage

// File: rtl/load_store_unit_align.sv
// Lane extraction, extension, sub-word merge and access legality.
// Purely combinational; the FSM in load_store_unit sequences it.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic [WID-1:0] word,
  input  logic [1:0]     off,
  input  logic [2:0]     funct3,
  input  logic           we,
  input  logic [15:0]    wsub,
  output logic [WID-1:0] ldata,
  output logic [WID-1:0] mdata,
  output logic           err
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        bad_f3;
  logic        mis;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];

    unique case (funct3)
      F3_B:    ldata = {{(WID-8){lane_b[7]}}, lane_b};
      F3_H:    ldata = {{(WID-16){lane_h[15]}}, lane_h};
      F3_BU:   ldata = {{(WID-8){1'b0}}, lane_b};
      F3_HU:   ldata = {{(WID-16){1'b0}}, lane_h};
      default: ldata = word;
    endcase

    mdata = word;
    if (funct3 == F3_B)
      mdata[{off, 3'b000} +: 8] = wsub[7:0];
    else if (funct3 == F3_H)
      mdata[{off[1], 4'b0000} +: 16] = wsub;

    // stores only have b/h/w; loads add the unsigned variants
    if (we)
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    mis = ((funct3[1:0] == 2'b01) && off[0])
       || ((funct3[1:0] == 2'b10) && (off != 2'b00));
    err = bad_f3 || mis;
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store FSM for a word-wide data memory; sub-word stores
// are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [2:0]     req_funct3,
  input  logic [WID-1:0] req_addr,
  input  logic [WID-1:0] req_wdata,
  output logic           resp_valid,
  output logic [WID-1:0] resp_rdata,
  output logic           resp_err,
  output logic [WID-1:0] mem_addr,
  output logic [WID-1:0] mem_wd,
  output logic           mem_we,
  input  logic [WID-1:0] mem_rd
);
  logic [2:0]     state_q, state_d;
  logic           we_q, we_d;
  logic [2:0]     f3_q, f3_d;
  logic [WID-1:0] addr_q, addr_d;
  logic [WID-1:0] wd_q, wd_d;
  logic [WID-1:0] rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           idle;
  logic           a_we;
  logic [2:0]     a_f3;
  logic [WID-1:0] a_addr;
  logic [WID-1:0] ldata;
  logic [WID-1:0] mdata;
  logic           a_err;

  // classify the live request in IDLE, the latched one afterwards
  assign idle   = (state_q == S_IDLE);
  assign a_we   = idle ? req_we     : we_q;
  assign a_f3   = idle ? req_funct3 : f3_q;
  assign a_addr = idle ? req_addr   : addr_q;

  assign req_ready  = idle;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = {a_addr[WID-1:2], 2'b00};
  assign mem_wd     = wd_q;
  assign mem_we     = (state_q == S_WRITE);

  lsu_align #(.WID(WID)) u_align (
    .word   (mem_rd),
    .off    (a_addr[1:0]),
    .funct3 (a_f3),
    .we     (a_we),
    .wsub   (wd_q[15:0]),
    .ldata  (ldata),
    .mdata  (mdata),
    .err    (a_err)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wd_d    = req_wdata;
          rdata_d = '0;
          err_d   = a_err;
          if (a_err)
            state_d = S_RESP;
          else if (!req_we)
            state_d = S_LOAD;
          else if (req_funct3 == F3_W)
            state_d = S_WRITE;
          else
            state_d = S_RMW_RD;
        end
      end
      (state_q == S_LOAD): begin
        rdata_d = ldata;
        state_d = S_RESP;
      end
      (state_q == S_RMW_RD): begin
        wd_d    = mdata;
        state_d = S_WRITE;
      end
      (state_q == S_WRITE): state_d = S_RESP;
      default:              state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a
// byte-addressed reference memory model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [64];
  logic [7:0]  rb [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_a = '0;
  logic [31:0] bd_d = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WID(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_a[7:2]] <= bd_d;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rword(input int a);
    int b;
    b = a & ~3;
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_a = 8'(a); bd_d = v;
    for (int k = 0; k < 4; k++) rb[(a & ~3) + k] = 8'(v >> (8 * k));
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // architectural reference: byte memory plus RV32I access rules
  task automatic model(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e_err, output logic [31:0] e_rd,
                       output int e_lat);
    int sz, off, base;
    logic legal;
    logic [31:0] v, m;
    sz = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2
       : (f3[1:0] == 2) ? 4 : 0;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    off = int'(a[1:0]);
    base = int'(a[7:0]) & ~3;
    e_err = !legal;
    if (!e_err && (off % sz != 0)) e_err = 1'b1;
    e_rd = 0;
    e_lat = 1;
    if (e_err) return;
    if (!we) begin
      v = rword(base) >> (8 * off);
      m = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
      v = v & m;
      if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~m;
      e_rd = v;
      e_lat = 2;
    end else begin
      for (int k = 0; k < sz; k++) rb[base + off + k] = 8'(wd >> (8 * k));
      e_lat = (sz == 4) ? 2 : 3;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("ready", 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd_o);
    logic e_err;
    logic [31:0] e_rd;
    int e_lat, n, wes;
    model(we, f3, a, wd, e_err, e_rd, e_lat);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; wes = 0;
    while (!resp_valid && n < 12) begin
      wes += int'(mem_we);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(e_lat));
    chk("err", 32'(resp_err), 32'(e_err));
    chk("rdata", resp_rdata, e_rd);
    chk("we_cycles", 32'(wes), 32'(we && !e_err));
    rd_o = resp_rdata;
  endtask

  initial begin
    logic [31:0] r;
    logic        d_err;
    logic [31:0] d_rd;
    int d_lat, n, acc, rv;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wd", mem_wd, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) set_word(i * 4, $urandom);

    set_word(32'h10, 32'h80817F01);
    txn(0, 3'b000, 32'h12, 0, r); chk("lb", r, 32'hFFFFFF81);
    txn(0, 3'b100, 32'h12, 0, r); chk("lbu", r, 32'h00000081);
    txn(0, 3'b001, 32'h12, 0, r); chk("lh", r, 32'hFFFF8081);
    txn(0, 3'b101, 32'h10, 0, r); chk("lhu", r, 32'h00007F01);
    txn(0, 3'b010, 32'h10, 0, r); chk("lw", r, 32'h80817F01);

    set_word(32'h10, 32'h11223344);
    txn(1, 3'b000, 32'h13, 32'hFFFFFFAB, r);
    chk("sb_word", mem[4], 32'hAB223344);

    set_word(32'h14, 32'hDEADBEEF);
    set_word(32'h18, 32'h5A5A0101);
    txn(1, 3'b001, 32'h16, 32'h00001234, r);
    chk("sh_word", mem[5], 32'h1234BEEF);
    chk("sh_next", mem[6], 32'h5A5A0101);

    txn(0, 3'b010, 32'h0A, 0, r); chk("e_lw", 32'(resp_err), 32'd1);
    txn(1, 3'b001, 32'h21, 32'h1, r); chk("e_sh", 32'(resp_err), 32'd1);
    txn(0, 3'b011, 32'h20, 0, r); chk("e_f3", 32'(resp_err), 32'd1);

    // reset during WRITE of an sb
    set_word(32'h20, 32'h0);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_rvalid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    repeat (4) begin
      @(posedge clk); #1;
      rv += int'(resp_valid);
    end
    chk("arst_noresp", 32'(rv), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_mem", mem[8], 32'h0);

    // back-to-back with req_valid held high
    model(1, 3'b010, 32'h30, 32'hCAFEF00D, d_err, d_rd, d_lat);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_we = 1'b0; req_wdata = 32'h0;
    n = 1; acc = 0; r = 32'hX;
    while (n < 12) begin
      rv = int'(req_ready);
      @(posedge clk); #1;
      n++;
      if (rv != 0 && acc == 0) begin
        acc = n;
        req_valid = 1'b0;
      end
      if (acc != 0 && n > acc && resp_valid) begin
        r = resp_rdata;
        break;
      end
    end
    chk("b2b_accept", 32'(acc), 32'd4);
    chk("b2b_lw", r, 32'hCAFEF00D);

    for (int i = 0; i < 200; i++) begin
      txn(1'($urandom), 3'($urandom), ($urandom % 64) * 4 + $urandom % 4,
          $urandom, r);
    end

    for (int i = 0; i < 64; i++) chk("mem_final", mem[i], rword(i * 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
